lc3_trap_unit: RTL

Multi-cycle TRAP sequencer for the pipelined LC-3. It accepts a TRAP instruction from decode and zero-extends trapvect8 into a vector-table address. It then reads the handler address over a request/grant/response memory port, writes the return PC to R7, and redirects fetch. It sits between decode, the data-memory arbiter and the register-file write port, and stalls the front end while busy.

---
 rtl/lc3_pkg.sv | 26 ++
 rtl/lc3_trap_unit_if.sv | 41 ++++
 rtl/lc3_trap_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions for the TRAP sequencer: widths, opcode/vector constants
// and the sequencer state encoding.
package lc3_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IR_W   = 16;
  localparam int unsigned VECT_W = 8;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0]   OP_TRAP       = 4'hF;
  localparam logic [VECT_W-1:0] TRAP_VEC_BASE = 8'h00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    WB    = 3'd4
  } trap_state_e;

  function automatic logic is_trap_op(input logic [OP_W-1:0] op);
    return op == OP_TRAP;
  endfunction

endpackage

// File: rtl/lc3_trap_unit_if.sv
// Decode / memory-port / R7 / redirect signals of the TRAP sequencer.
// The slave modport is the unit itself; master is its environment.
interface lc3_trap_unit_if;
  import lc3_pkg::*;

  logic              trap_valid_i;
  logic              trap_ready_o;
  logic [IR_W-1:0]   trap_ir_i;
  logic [DATA_W-1:0] trap_pc_i;
  logic              flush_i;

  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              r7_we_o;
  logic [DATA_W-1:0] r7_data_o;
  logic              redirect_valid_o;
  logic [DATA_W-1:0] redirect_pc_o;
  logic              stall_o;
  logic              illegal_o;

  modport slave (
    input  trap_valid_i, trap_ir_i, trap_pc_i, flush_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output trap_ready_o, mem_req_o, mem_addr_o,
    output r7_we_o, r7_data_o, redirect_valid_o, redirect_pc_o,
    output stall_o, illegal_o
  );

  modport master (
    output trap_valid_i, trap_ir_i, trap_pc_i, flush_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  trap_ready_o, mem_req_o, mem_addr_o,
    input  r7_we_o, r7_data_o, redirect_valid_o, redirect_pc_o,
    input  stall_o, illegal_o
  );

endinterface

// File: rtl/lc3_trap_unit.sv
// Multi-cycle LC-3 TRAP sequencer: fetch handler address from the vector table,
// write the return PC to R7 and redirect fetch. All outputs come straight from flops.
module lc3_trap_unit
  import lc3_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  lc3_trap_unit_if.slave bus
);

  trap_state_e       state_q, state_d;
  logic [VECT_W-1:0] vect_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] handler_q;
  logic              ready_q, req_q, stall_q, wb_q, illegal_q;

  logic accept_c;
  logic take_trap_c;
  logic take_illegal_c;
  logic unused_ir_c;

  assign accept_c       = bus.trap_valid_i & (state_q == IDLE);
  assign take_trap_c    = accept_c & ~bus.flush_i &  is_trap_op(bus.trap_ir_i[15:12]);
  assign take_illegal_c = accept_c & ~bus.flush_i & ~is_trap_op(bus.trap_ir_i[15:12]);
  assign unused_ir_c    = ^bus.trap_ir_i[11:8];

  // Next-state: flush squashes before grant, drains an outstanding read after it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take_trap_c) state_d = REQ;
      end
      REQ: begin
        if (bus.mem_gnt_i)    state_d = bus.flush_i ? DRAIN : WAIT;
        else if (bus.flush_i) state_d = IDLE;
      end
      WAIT: begin
        if (bus.mem_rvalid_i) state_d = bus.flush_i ? IDLE : WB;
        else if (bus.flush_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.mem_rvalid_i) state_d = IDLE;
      end
      WB: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, payload latches and output flops decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vect_q    <= '0;
      pc_q      <= '0;
      handler_q <= '0;
      ready_q   <= 1'b1;
      req_q     <= 1'b0;
      stall_q   <= 1'b0;
      wb_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == IDLE);
      req_q     <= (state_d == REQ);
      stall_q   <= (state_d != IDLE);
      wb_q      <= (state_d == WB);
      illegal_q <= take_illegal_c;
      if (take_trap_c) begin
        vect_q <= bus.trap_ir_i[VECT_W-1:0];
        pc_q   <= bus.trap_pc_i;
      end
      if ((state_q == WAIT) && bus.mem_rvalid_i && !bus.flush_i) begin
        handler_q <= bus.mem_rdata_i;
      end
    end
  end

  // Vector-table address is zero-extended: base byte above trapvect8.
  assign bus.mem_addr_o       = ADDR_W'({TRAP_VEC_BASE, vect_q});
  assign bus.trap_ready_o     = ready_q;
  assign bus.mem_req_o        = req_q;
  assign bus.r7_we_o          = wb_q;
  assign bus.r7_data_o        = pc_q;
  assign bus.redirect_valid_o = wb_q;
  assign bus.redirect_pc_o    = handler_q;
  assign bus.stall_o          = stall_q;
  assign bus.illegal_o        = illegal_q;

endmodule
